// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, data-length bounds and the
// parity helper used by both uart_tx and uart_rx.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PAR,
        STOP1,
        STOP2,
        DONE,
        WAIT_HIGH
    } rx_state_t;

    localparam logic [3:0] DATA_LEN_MIN = 4'd5;
    localparam logic [3:0] DATA_LEN_MAX = 4'd8;

    localparam logic PARITY_XOR  = 1'b1;
    localparam logic PARITY_XNOR = 1'b0;

    function automatic logic len_valid(input logic [3:0] len);
        return (len >= DATA_LEN_MIN) && (len <= DATA_LEN_MAX);
    endfunction

    // An out-of-range length falls back to a full byte
    function automatic logic [3:0] eff_len(input logic [3:0] len);
        return len_valid(len) ? len : DATA_LEN_MAX;
    endfunction

    function automatic logic parity_calc(input logic [7:0] data,
                                         input logic [3:0] len,
                                         input logic       ptype);
        logic acc;
        acc = 1'b0;
        for (int i = 0; i < 8; i++) begin
            acc = acc ^ (data[i] & (4'(i) < len));
        end
        return len_valid(len) ? ((ptype == PARITY_XOR) ? acc : ~acc) : 1'b0;
    endfunction

endpackage

// File: rtl/uart_sync.sv
// Multi-flop synchronizer for the asynchronous serial line; resets to the
// idle (high) level so reset release never looks like a start bit.
module uart_sync
    import uart_pkg::*;
#(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain_r;

    // Shift the raw line through the flop chain
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            chain_r <= '1;
        end else begin
            chain_r <= {chain_r[STAGES-2:0], d};
        end
    end

    assign q = chain_r[STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// UART receiver: recovers start/data/parity/stop frames from an oversampled
// line and presents the byte plus error flags with a one-cycle done pulse.
module uart_rx
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic       rx_clk,
    input  logic       rst,
    input  logic       rx,
    input  logic       parity_en,
    input  logic       parity_type,
    input  logic [3:0] data_len,
    input  logic       stop2,
    output logic [7:0] rx_data,
    output logic       rx_done,
    output logic       parity_err,
    output logic       frame_err
);

    localparam int TICK_W = $clog2(OVERSAMPLE);
    localparam logic [TICK_W-1:0] TICK_MID  = TICK_W'(OVERSAMPLE / 2 - 1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);

    rx_state_t         state_r;
    logic [TICK_W-1:0] tick_r;
    logic [2:0]        bit_idx_r;
    logic [7:0]        data_r;
    logic              cfg_par_en_r;
    logic              cfg_par_type_r;
    logic [3:0]        cfg_len_r;
    logic              cfg_stop2_r;
    logic              par_mis_r;
    logic              stop_bad_r;
    logic              rx_s;
    logic [2:0]        last_idx_s;
    logic              exp_par_s;

    uart_sync #(.STAGES(SYNC_STAGES)) u_sync (
        .clk (rx_clk),
        .rst (rst),
        .d   (rx),
        .q   (rx_s)
    );

    assign last_idx_s = 3'(eff_len(cfg_len_r) - 4'd1);
    assign exp_par_s  = parity_calc(data_r, cfg_len_r, cfg_par_type_r);

    // Frame sequencer: bit timing, capture and registered host-side outputs
    always_ff @(posedge rx_clk or negedge rst) begin
        if (!rst) begin
            state_r        <= IDLE;
            tick_r         <= '0;
            bit_idx_r      <= 3'd0;
            data_r         <= 8'd0;
            cfg_par_en_r   <= 1'b0;
            cfg_par_type_r <= 1'b0;
            cfg_len_r      <= 4'd0;
            cfg_stop2_r    <= 1'b0;
            par_mis_r      <= 1'b0;
            stop_bad_r     <= 1'b0;
            rx_data        <= 8'd0;
            rx_done        <= 1'b0;
            parity_err     <= 1'b0;
            frame_err      <= 1'b0;
        end else begin
            rx_done <= 1'b0;
            tick_r  <= (tick_r == TICK_LAST) ? '0 : tick_r + TICK_W'(1);
            case (state_r)
                IDLE: begin
                    tick_r <= '0;
                    if (!rx_s) begin
                        state_r <= START;
                    end
                end
                START: begin
                    // A line that is high again at mid start bit was a glitch
                    if (tick_r == TICK_MID) begin
                        tick_r <= '0;
                        if (rx_s) begin
                            state_r <= IDLE;
                        end else begin
                            cfg_par_en_r   <= parity_en;
                            cfg_par_type_r <= parity_type;
                            cfg_len_r      <= data_len;
                            cfg_stop2_r    <= stop2;
                            data_r         <= 8'd0;
                            bit_idx_r      <= 3'd0;
                            par_mis_r      <= 1'b0;
                            stop_bad_r     <= 1'b0;
                            state_r        <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (tick_r == TICK_LAST) begin
                        data_r[bit_idx_r] <= rx_s;
                        if (bit_idx_r == last_idx_s) begin
                            bit_idx_r <= 3'd0;
                            tick_r    <= '0;
                            state_r   <= cfg_par_en_r ? PAR : STOP1;
                        end else begin
                            bit_idx_r <= bit_idx_r + 3'd1;
                        end
                    end
                end
                PAR: begin
                    if (tick_r == TICK_LAST) begin
                        par_mis_r <= rx_s ^ exp_par_s;
                        tick_r    <= '0;
                        state_r   <= STOP1;
                    end
                end
                STOP1: begin
                    if (tick_r == TICK_LAST) begin
                        tick_r <= '0;
                        if (cfg_stop2_r) begin
                            stop_bad_r <= ~rx_s;
                            state_r    <= STOP2;
                        end else begin
                            rx_done    <= 1'b1;
                            rx_data    <= data_r;
                            parity_err <= par_mis_r;
                            frame_err  <= ~rx_s;
                            state_r    <= DONE;
                        end
                    end
                end
                STOP2: begin
                    if (tick_r == TICK_LAST) begin
                        tick_r     <= '0;
                        rx_done    <= 1'b1;
                        rx_data    <= data_r;
                        parity_err <= par_mis_r;
                        frame_err  <= stop_bad_r | ~rx_s;
                        state_r    <= DONE;
                    end
                end
                DONE: begin
                    // A line still low here is a break or bad stop: wait it out
                    tick_r  <= '0;
                    state_r <= rx_s ? IDLE : WAIT_HIGH;
                end
                WAIT_HIGH: begin
                    tick_r <= '0;
                    if (rx_s) begin
                        state_r <= IDLE;
                    end
                end
                default: begin
                    tick_r  <= '0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule
